// File: rtl/sprite_mem_pkg.sv
// Shared definitions for the sprite memory subsystem: default geometry and
// the slot encoding used by the SRAM arbiter.
package sprite_mem_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 16;

    // What the single SRAM port does in a given cycle.
    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_READ  = 2'd1,
        SLOT_WRITE = 2'd2
    } slot_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-write buffer: synchronous FIFO of address/data pairs. Besides the
// head entry it exposes per-entry valid bits and addresses so the arbiter
// can detect a read that targets a still-buffered write.
module wbuf_fifo
    import sprite_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 4,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [ADDR_WIDTH-1:0]       push_addr,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        pop,
    output logic [ADDR_WIDTH-1:0]       head_addr,
    output logic [DATA_WIDTH-1:0]       head_data,
    output logic [CW-1:0]               count,
    output logic [DEPTH-1:0]            entry_valid,
    output logic [DEPTH*ADDR_WIDTH-1:0] entry_addr
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic [DEPTH-1:0]      vld;
    logic                  do_push;
    logic                  do_pop;

    // Overflow/underflow requests are ignored so the pointers never corrupt.
    assign do_push = push && (cnt != DEPTH_C);
    assign do_pop  = pop && (cnt != '0);

    // Entry storage; contents are don't-care until marked valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and valid bits; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Flatten the stored addresses for the hazard comparators.
    always_comb begin
        entry_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_mem[i];
        end
    end

    assign head_addr   = addr_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign count       = cnt;
    assign entry_valid = vld;

endmodule

// File: rtl/sprite_sram_arbiter.sv
// Arbiter sharing one single-port sprite SRAM between the VGA read client
// and the posted-write animation/loader client. Reads win unless the write
// buffer has waited STARVE_LIMIT read slots or a read hits a buffered write.
//
// Handshakes: a write transfers in any cycle where wr_valid && wr_ready;
// wr_ready never depends on wr_valid. A read request (rd_req) is held with a
// stable rd_addr until rd_gnt is seen; rd_valid follows one cycle later.
module sprite_sram_arbiter
    import sprite_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int WBUF_DEPTH   = 4,
    parameter int STARVE_LIMIT = 7,
    localparam int CW          = $clog2(WBUF_DEPTH) + 1,
    localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic [CW-1:0]         wbuf_count
);

    localparam logic [CW-1:0] DEPTH_C    = CW'(WBUF_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    slot_t                          slot;
    logic                           push;
    logic                           pop;
    logic                           buf_nonempty;
    logic                           hazard;
    logic [ADDR_WIDTH-1:0]          head_addr;
    logic [DATA_WIDTH-1:0]          head_data;
    logic [WBUF_DEPTH-1:0]          entry_valid;
    logic [WBUF_DEPTH*ADDR_WIDTH-1:0] entry_addr;
    logic [SW-1:0]                  starve_cnt;
    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [DATA_WIDTH-1:0]          wdata_q;

    assign wr_ready     = (wbuf_count < DEPTH_C) && !reset;
    assign push         = wr_valid && wr_ready;
    assign pop          = (slot == SLOT_WRITE);
    assign buf_nonempty = (wbuf_count != '0);

    wbuf_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (wr_addr),
        .push_data   (wr_data),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (wbuf_count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // A read aimed at an address still sitting in the buffer must wait for
    // the drain; the entry being enqueued right now is not yet valid, so a
    // same-cycle read sees the old SRAM contents.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if (entry_valid[i] && (entry_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr)) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && rd_req;
    end

    // Slot decision in priority order: reset, forced/idle write, read, idle.
    always_comb begin
        slot = SLOT_IDLE;
        if (reset) begin
            slot = SLOT_IDLE;
        end else if (buf_nonempty && (!rd_req || (starve_cnt == STARVE_MAX) || hazard)) begin
            slot = SLOT_WRITE;
        end else if (rd_req) begin
            slot = SLOT_READ;
        end
    end

    // SRAM port drive; address and write data hold when the port is idle.
    always_comb begin
        rd_gnt     = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
        case (slot)
            SLOT_WRITE: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = head_addr;
                sram_wdata = head_data;
            end
            SLOT_READ: begin
                rd_gnt    = 1'b1;
                sram_en   = 1'b1;
                sram_addr = rd_addr;
            end
            default: begin
                rd_gnt  = 1'b0;
                sram_en = 1'b0;
            end
        endcase
    end

    // Remember the last driven address/data for idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= sram_addr;
            wdata_q <= sram_wdata;
        end
    end

    // Count read slots taken while writes wait; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if ((slot == SLOT_WRITE) || !buf_nonempty) begin
            starve_cnt <= '0;
        end else if ((slot == SLOT_READ) && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Read data arrives one cycle after the grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_gnt;
        end
    end

    assign rd_data = sram_rdata;

endmodule

// File: tb/tb_sprite_sram_arbiter.sv
// Bench for sprite_sram_arbiter with a behavioural write-first SRAM, a
// reference memory updated at write acceptance, and scoreboards for read
// data and SRAM write commit order.
module tb_sprite_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        sram_en;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;
    logic [2:0]  wbuf_count;

    logic [7:0]  sram_mem [0:65535];
    logic [7:0]  ref_mem  [0:65535];
    logic [7:0]  exp_q [$];
    logic [23:0] exp_wq [$];
    logic [7:0]  old_q [$];

    int total = 0;
    int bad   = 0;
    logic last_gnt;
    logic acc;

    always #5 clk = ~clk;

    sprite_sram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .wbuf_count (wbuf_count)
    );

    // Single-port SRAM, registered read, write-first data_o.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                sram_mem[sram_addr] <= sram_wdata;
                sram_rdata          <= sram_wdata;
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rnd_addr();
        return 16'($urandom_range(16'h0100, 16'h01FF));
    endfunction

    // Per-cycle observation at the falling edge.
    task automatic monitor();
        logic [23:0] e;
        logic [7:0]  o;
        acc = 1'b0;
        if (reset) begin
            check("rst_sram_en", sram_en, 0);
            check("rst_rd_gnt", rd_gnt, 0);
            check("rst_wr_ready", wr_ready, 0);
            // buffered writes are discarded: undo them in the reference
            while (exp_wq.size() > 0) begin
                e = exp_wq.pop_back();
                o = old_q.pop_back();
                ref_mem[e[23:8]] = o;
            end
        end else begin
            check("wbuf_count", wbuf_count, exp_wq.size());
        end
        if (rd_valid) begin
            if (exp_q.size() == 0) check("rd_extra", 1, 0);
            else check("rd_data", rd_data, exp_q.pop_front());
        end
        if (sram_en && sram_we) begin
            check("wr_with_gnt", rd_gnt, 0);
            if (exp_wq.size() == 0) check("wr_extra", 1, 0);
            else begin
                e = exp_wq.pop_front();
                o = old_q.pop_front();
                check("wr_commit", {sram_addr, sram_wdata}, e);
            end
        end
        if (rd_gnt) begin
            check("gnt_addr", sram_addr, rd_addr);
            check("gnt_en", sram_en, 1);
            exp_q.push_back(ref_mem[rd_addr]);
        end
        if (wr_valid && wr_ready) begin
            old_q.push_back(ref_mem[wr_addr]);
            ref_mem[wr_addr] = wr_data;
            exp_wq.push_back({wr_addr, wr_data});
            acc = 1'b1;
        end
        last_gnt = rd_gnt;
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic read_addr(input logic [15:0] a);
        logic got = 1'b0;
        rd_req  = 1'b1;
        rd_addr = a;
        for (int c = 0; c < 20 && !got; c++) begin
            sample();
            got = rd_gnt;
            advance();
        end
        check("rd_granted", got, 1);
        rd_req = 1'b0;
        sample();
        advance();
    endtask

    initial begin
        int reads;
        logic seen;
        int idx;
        logic [7:0] vals [5];

        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 8'(i) ^ 8'h3C;
            ref_mem[i]  = 8'(i) ^ 8'h3C;
        end
        sram_mem[16'h0010] = 8'h5A;
        ref_mem[16'h0010]  = 8'h5A;

        reset = 1'b1; rd_req = 1'b0; rd_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 3; i++) begin sample(); advance(); end
        reset = 1'b0;

        // reset values / idle
        sample();
        check("idle_count", wbuf_count, 0);
        check("idle_rd_valid", rd_valid, 0);
        check("idle_wr_ready", wr_ready, 1);
        check("idle_sram_en", sram_en, 0);
        check("idle_rd_gnt", rd_gnt, 0);
        advance();

        // single read
        rd_req = 1'b1; rd_addr = 16'h0010;
        sample();
        check("t2_gnt", rd_gnt, 1);
        advance();
        rd_req = 1'b0;
        sample();
        check("t2_valid", rd_valid, 1);
        check("t2_data", rd_data, 8'h5A);
        advance();

        // starvation forcing
        rd_req = 1'b1; rd_addr = rnd_addr();
        wr_valid = 1'b1; wr_addr = 16'h0020; wr_data = 8'h11;
        sample();
        check("t3_acc", acc, 1);
        advance();
        wr_valid = 1'b0;
        if (last_gnt) rd_addr = rnd_addr();
        reads = 0; seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            sample();
            if (sram_en && sram_we) begin
                seen = 1'b1;
                check("t3_force_gnt", rd_gnt, 0);
                check("t3_force_addr", sram_addr, 16'h0020);
            end else if (rd_gnt) reads++;
            advance();
            if (last_gnt) rd_addr = rnd_addr();
        end
        check("t3_seen", seen, 1);
        check("t3_reads", reads, 7);
        sample();
        check("t3_resume", rd_gnt, 1);
        advance();
        rd_addr = rnd_addr();

        // hazard
        wr_valid = 1'b1; wr_addr = 16'h0030; wr_data = 8'hA5;
        sample();
        check("t4_acc", acc, 1);
        check("t4_acc_gnt", rd_gnt, 1);
        advance();
        wr_valid = 1'b0; rd_addr = 16'h0030;
        sample();
        check("t4_drain", sram_en && sram_we, 1);
        check("t4_nogrant", rd_gnt, 0);
        advance();
        sample();
        check("t4_gnt", rd_gnt, 1);
        advance();
        rd_req = 1'b0;
        sample();
        check("t4_valid", rd_valid, 1);
        check("t4_data", rd_data, 8'hA5);
        advance();

        // fill the buffer under continuous reads
        for (int i = 0; i < 5; i++) vals[i] = 8'($urandom_range(0, 255));
        idx = 0; rd_req = 1'b1; rd_addr = rnd_addr();
        for (int c = 0; c < 300 && (idx < 5 || exp_wq.size() > 0); c++) begin
            wr_valid = (idx < 5);
            wr_addr  = 16'h0040 + 16'(idx);
            wr_data  = (idx < 5) ? vals[idx] : 8'h00;
            sample();
            if (c == 4) begin
                check("t5_full_rdy", wr_ready, 0);
                check("t5_full_cnt", wbuf_count, 4);
            end
            if (acc) idx++;
            advance();
            if (last_gnt) rd_addr = rnd_addr();
        end
        wr_valid = 1'b0; rd_req = 1'b0;
        check("t5_all_acc", idx, 5);
        check("t5_drained", exp_wq.size(), 0);
        for (int i = 0; i < 5; i++) read_addr(16'h0040 + 16'(i));

        // reset with buffered writes
        rd_req = 1'b1; rd_addr = rnd_addr();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_addr = 16'h0050 + 16'(i); wr_data = 8'hC1 + 8'(i);
            sample();
            check("t6_acc", acc, 1);
            advance();
            if (last_gnt) rd_addr = rnd_addr();
        end
        wr_valid = 1'b0;
        reset = 1'b1;
        sample();
        advance();
        reset = 1'b0; rd_req = 1'b0;
        sample();
        check("t6_cnt", wbuf_count, 0);
        check("t6_valid", rd_valid, 0);
        check("t6_en", sram_en, 0);
        advance();
        for (int i = 0; i < 10; i++) begin sample(); advance(); end
        read_addr(16'h0050);
        read_addr(16'h0052);

        check("sb_rd_empty", exp_q.size(), 0);
        check("sb_wr_empty", exp_wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sprite_sram_arbiter.md
# sprite_sram_arbiter

Shares one single-port sprite SRAM (1-cycle registered read, write-first on `data_o`) between two clients:
- the VGA pixel-fetch pipeline (read client);
- the animation/loader engine (write client).

Reads have priority. Writes are posted into a small buffer and drained into idle or forced slots. A starvation limit bounds write latency, and an address-hazard check keeps reads coherent with buffered writes. The block sits between the sprite SRAM instance and the display/animation logic.

## Interface
- `DATA_WIDTH`, 8: SRAM word width.
- `ADDR_WIDTH`, 16: SRAM address width.
- `WBUF_DEPTH`, 4: posted-write buffer entries; power of two, ≥ 2.
- `STARVE_LIMIT`, 7: consecutive read-won cycles with a pending write before a write is forced; ≥ 1.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `rd_req`  in  1  read request; held with `rd_addr` stable until granted.
- `rd_addr`  in  ADDR_WIDTH  read address.
- `rd_gnt`  out  1  combinational; read issued to SRAM this cycle.
- `rd_valid`  out  1  registered; `rd_data` valid.
- `rd_data`  out  DATA_WIDTH  pass-through of `sram_rdata`.
- `wr_valid`  in  1  write offer.
- `wr_ready`  out  1  combinational; buffer can accept.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `sram_en`  out  1  SRAM enable.
- `sram_we`  out  1  SRAM write enable.
- `sram_addr`  out  ADDR_WIDTH  SRAM address.
- `sram_wdata`  out  DATA_WIDTH  SRAM write data.
- `sram_rdata`  in  DATA_WIDTH  SRAM `data_o`.
- `wbuf_count`  out  clog2(WBUF_DEPTH)+1  registered occupancy.

## Operation
**Write buffer**
- FIFO holding address/data entries.
- Enqueue when `wr_valid && wr_ready`.
- `wr_ready = (wbuf_count < WBUF_DEPTH) && !reset`. No full-with-drain bypass.

**Hazard**
- `hazard = rd_req` and `rd_addr` equals the address of any *stored* entry.
- The entry being enqueued this cycle is excluded from the check.

**Slot decision, evaluated each cycle in priority order**
1. `reset`: `sram_en=0`, `rd_gnt=0`.
2. WRITE when the buffer is non-empty and any of these holds: `!rd_req`, `starve_cnt == STARVE_LIMIT`, or `hazard`.
   - Drives `sram_en=1`, `sram_we=1`, and the head entry's address/data.
   - Dequeues the head.
3. READ when `rd_req` is asserted.
   - Drives `rd_gnt=1`, `sram_en=1`, `sram_we=0`, `sram_addr=rd_addr`.
4. IDLE otherwise.
   - Drives `sram_en=0`, `sram_we=0`.
   - `sram_addr` and `sram_wdata` hold their last driven values.

**Starvation counter (`starve_cnt`)**
- Width clog2(STARVE_LIMIT+1).
- +1 on a READ slot while the buffer is non-empty; saturates at STARVE_LIMIT.
- Cleared on a WRITE slot or whenever the buffer is empty.

**Boundary behaviour**
- A write enqueued into an empty buffer cannot drain in the same cycle; it becomes eligible the next cycle.
- Simultaneous enqueue and dequeue leaves `wbuf_count` unchanged.
- A read granted in the same cycle as an enqueue to the same address returns the old data (read ordered first).
- Write pointers wrap modulo WBUF_DEPTH.
- Reset mid-operation discards buffered writes and clears `rd_valid` on the next edge. No SRAM access occurs during reset.

## Timing
- Reset values: `wbuf_count=0`, `starve_cnt=0`, `rd_valid=0`, pointers=0.
- Read latency: a grant in cycle N produces `rd_valid=1` and valid `rd_data` in cycle N+1. `rd_valid` is `rd_gnt` registered.
- Write acceptance is 0 cycles; SRAM commit happens at the earliest 1 cycle after acceptance.
- Worst-case write drain: (STARVE_LIMIT+1) × `wbuf_count` cycles under continuous reads.
- All `sram_*` outputs are combinational from registered state and the current `rd_req`/`rd_addr`. There is no added pipeline stage.

## Structure
- Shared package `sprite_mem_pkg` holds the default DATA_WIDTH/ADDR_WIDTH and the slot encoding constants `SLOT_IDLE`, `SLOT_READ`, `SLOT_WRITE`.
- Sub-module `wbuf_fifo`:
  - synchronous FIFO, parameterised depth;
  - exports head entry, count, and per-entry valid/address vectors for the hazard compare.
- Arbitration, starvation counter and `rd_valid` register stay in the top module.

## Test plan
- Reset then idle: all outputs at reset values, `wr_ready=1` after `reset` deasserts, `sram_en=0`.
- Single read, addr 0x0010 holding 0x5A, no writes: `rd_gnt` in cycle N; `rd_valid=1`, `rd_data=0x5A` in N+1.
- Continuous `rd_req` plus one write (0x0020←0x11), STARVE_LIMIT=7: reads win 7 cycles, the write is forced on the 8th, `rd_gnt=0` that cycle, then reads resume.
- Hazard case:
  - post write 0x0030←0xA5 while reads are continuous;
  - then read 0x0030.
  - Required: the write drains first, the read is granted next cycle, and returns 0xA5.
- Fill with 4 posted writes while reads are continuous:
  - `wr_ready=0` at count 4, and a fifth `wr_valid` is held off.
  - Writes commit in FIFO order; read back returns the values in order.
- Assert `reset` with 3 buffered writes: next cycle count=0, `rd_valid=0`, no SRAM write ever issued for those entries.
